// File: rtl/seg7_scan_driver_if.sv
// Bundle of the value/control inputs and display outputs of the
// seven-segment scan driver.
interface seg7_scan_driver_if;
   logic [15:0] value;        // four hex nibbles, nibble d -> digit d
   logic        load;         // strobe: capture value for the next frame
   logic [3:0]  blank;        // per-digit force-dark
   logic        lzb;          // leading-zero blanking enable
   logic [0:6]  SSeg;         // segments a..g, active-low
   logic [3:0]  an;           // anodes, active-low, one-hot-low
   logic        frame_start;  // pulse when digit 0 becomes active

   modport master (
      output value, load, blank, lzb,
      input  SSeg, an, frame_start
   );

   modport slave (
      input  value, load, blank, lzb,
      output SSeg, an, frame_start
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed four-digit seven-segment driver. A value is double
// buffered: loads land in a pending register and are promoted to the
// displayed register only at the frame boundary (digit 3 -> digit 0), so
// a frame never mixes nibbles of two different values.
module seg7_scan_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_driver_if.slave   bus
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [15:0]      active_q, active_d;
   logic [15:0]      pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [3:0]       an_q, an_d;
   logic [0:6]       sseg_q, sseg_d;
   logic             fs_q, fs_d;

   logic             tick, swap, lz_blank, dig_blank;
   logic [3:0]       nib;

   // Hex nibble to abcdefg, active-low (index 0 = segment a).
   function automatic logic [0:6] hex2seg(input logic [3:0] h);
      case (h)
         4'h0: hex2seg = 7'b0000001;
         4'h1: hex2seg = 7'b1001111;
         4'h2: hex2seg = 7'b0010010;
         4'h3: hex2seg = 7'b0000110;
         4'h4: hex2seg = 7'b1001100;
         4'h5: hex2seg = 7'b0100100;
         4'h6: hex2seg = 7'b0100000;
         4'h7: hex2seg = 7'b0001111;
         4'h8: hex2seg = 7'b0000000;
         4'h9: hex2seg = 7'b0000100;
         4'hA: hex2seg = 7'b0001000;
         4'hB: hex2seg = 7'b1100000;
         4'hC: hex2seg = 7'b0110001;
         4'hD: hex2seg = 7'b1000010;
         4'hE: hex2seg = 7'b0110000;
         default: hex2seg = 7'b0111000;
      endcase
   endfunction

   assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));
   assign swap = tick && (sel_q == 2'd3);

   // Next-state: prescaler, digit select, double buffer and output decode.
   always_comb begin
      cnt_d      = tick ? '0 : cnt_q + 1'b1;
      sel_d      = tick ? sel_q + 2'd1 : sel_q;
      active_d   = active_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;

      if (swap) begin
         // A load coinciding with the swap bypasses the pending register.
         if (bus.load) begin
            active_d   = bus.value;
         end else if (pend_vld_q) begin
            active_d   = pend_q;
         end
         pend_vld_d = 1'b0;
      end else if (bus.load) begin
         pend_d     = bus.value;
         pend_vld_d = 1'b1;
      end

      // Leading-zero test uses the post-swap value so digit 0's frame is
      // consistent with the nibbles that follow.
      case (sel_d)
         2'd1:    lz_blank = bus.lzb && (active_d[15:4]  == 12'd0);
         2'd2:    lz_blank = bus.lzb && (active_d[15:8]  == 8'd0);
         2'd3:    lz_blank = bus.lzb && (active_d[15:12] == 4'd0);
         default: lz_blank = 1'b0;
      endcase
      dig_blank = bus.blank[sel_d] || lz_blank;
      nib       = active_d[{sel_d, 2'b00} +: 4];

      an_d   = an_q;
      sseg_d = sseg_q;
      if (tick) begin
         an_d   = ~(4'b0001 << sel_d);
         sseg_d = dig_blank ? 7'b1111111 : hex2seg(nib);
      end
      fs_d = swap;
   end

   // State registers; reset dominates and discards any pending load.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         sel_q      <= 2'd3;
         active_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         an_q       <= 4'b1111;
         sseg_q     <= 7'b1111111;
         fs_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         active_q   <= active_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         an_q       <= an_d;
         sseg_q     <= sseg_d;
         fs_q       <= fs_d;
      end
   end

   assign bus.an          = an_q;
   assign bus.SSeg        = sseg_q;
   assign bus.frame_start = fs_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the adder/decoder blocks.
- Takes a 16-bit value as four hex nibbles and drives all four digits of the board's multiplexed seven-segment display.
- Replaces the fixed anode pattern with a time-multiplexed anode scan.
- Value updates are double-buffered and applied only at frame boundaries, so a digit never shows a torn value.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit. Minimum 2.
- CNT_W, 16: prescaler width. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous reset, active-high.
- value  in  16: nibble d (value[4d+3:4d]) is shown on digit d. Digit 0 is rightmost.
- load  in  1: single-cycle strobe that captures value into the pending register.
- blank  in  4: blank[d]=1 forces digit d dark.
- lzb  in  1: leading-zero blanking enable.
- SSeg  out  [0:6]: segments a,b,c,d,e,f,g in index order 0..6, active-low. Registered.
- an  out  4: anodes, active-low, one-hot-low. Registered.
- frame_start  out  1: one-cycle pulse when digit 0 becomes active.

Behaviour:
- Sync reset:
  - prescaler cnt=0, digit select sel=3.
  - active_val=0, pend_val=0, pend_valid=0.
  - an=4'b1111, SSeg=7'b1111111, frame_start=0.
  - rst has priority over all inputs. Asserting rst mid-frame returns to this state in the next cycle, and any pending load is discarded.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick=1 combinationally when cnt==REFRESH_DIV-1.
- Digit select:
  - On tick, sel <= sel+1 (mod 4; 3 wraps to 0).
  - The first tick after reset selects digit 0.
- Frame swap (tick with sel==3):
  - If load=1 in the same cycle: active_val <= value, pend_valid <= 0 (bypass; load wins).
  - Else if pend_valid=1: active_val <= pend_val, pend_valid <= 0.
  - Else active_val holds.
  - frame_start <= 1 for exactly one cycle, coincident with an first becoming 4'b1110.
- Load outside a swap cycle:
  - pend_val <= value, pend_valid <= 1.
  - Multiple loads within one frame: the last one wins.
  - active_val is never changed mid-frame.
- Outputs:
  - Registered and updated in the cycle after tick.
  - Latency from tick to new an/SSeg is 1 cycle.
  - an per new sel: 0->4'b1110, 1->4'b1101, 2->4'b1011, 3->4'b0111.
  - SSeg is the decode of active_val nibble[new sel], using post-swap active_val for digit 0.
- Decode, hex to abcdefg, active-low:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Blanking:
  - Digit d is blank if blank[d]=1, or if lzb=1 and d>0 and nibbles d..3 of active_val are all zero.
  - Digit 0 is never leading-zero-blanked.
  - A blank digit drives SSeg=7'b1111111 while an still selects it, so scan timing is unchanged.
  - blank and lzb are sampled live at each tick, not buffered.
- Between ticks, an and SSeg hold steady. Exactly one anode is low at any time after the first tick.

Test Plan (REFRESH_DIV=4):
- Reset then idle: an=1111, SSeg=1111111 for cycles 0..3. Cycle after first tick: an=1110, SSeg=0000001, frame_start=1 for one cycle. Thereafter an steps 1110->1101->1011->0111 every 4 cycles, with frame_start every 16 cycles.
- load with value=16'h12AF mid-frame: digits are unchanged until the next frame_start. Then digit0=0111000 (F), digit1=0001000 (A), digit2=0010010 (2), digit3=1001111 (1).
- Two loads in one frame (16'h1111, then 16'h0042), and separately load asserted on the swap tick with 16'h00C3: the next frame shows 0042. The bypass case shows 00C3 in the immediately starting frame.
- lzb=1 with active 16'h0042: digits 3 and 2 give SSeg=1111111, digit1=1001100, digit0=0010010. Active 16'h0000 shows only digit0=0000001.
- blank=4'b0101 with active 16'h8888: digits 0 and 2 are dark, digits 1 and 3 are 0000000. Anode sequence is unchanged.
- rst asserted mid-frame with a pending load: next cycle an=1111, SSeg=1111111, and the pending value is lost. The first frame after reset shows 0000.
